mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have: req_valid  in  1  load/store request present.
REQ-004 SHALL have: req_ready  out  1  unit can accept a request this cycle.
REQ-005 SHALL have: req_addr  in  32  byte address; req_wdata  in  32  store data, right-justified.
REQ-006 SHALL have: req_mask  in  3  load kind (000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU).
REQ-007 SHALL have: req_memwrite  in  2  store kind (00 load, 01 SB, 10 SH, 11 SW).
REQ-008 SHALL have: mem_en  out  1; mem_we  out  4; mem_addr  out  30 (word address); mem_wdata  out  32.
REQ-009 SHALL have: mem_rvalid  in  1  memory completion (loads and stores); mem_rdata  in  32.
REQ-010 SHALL have: resp_valid  out  1; resp_rdata  out  32; resp_misaligned  out  1.

Function
REQ-011 SHALL implement FSM IDLE, ACCESS, WAIT, RESP; req_ready=1 only in IDLE.
REQ-012 Accept = req_valid&&req_ready at edge N; request fields SHALL be registered at that edge.
REQ-013 Misaligned = (LH/LHU/SH with addr[0]=1) or (LW/SW with addr[1:0]!=0); on accept, FSM SHALL go to RESP with resp_misaligned=1, resp_rdata=0, no memory access.
REQ-014 Aligned accept: ACCESS in cycle N+1 SHALL drive mem_en=1 for exactly one cycle, mem_addr=addr[31:2].
REQ-015 Byte lanes big-endian: addr[1:0]=0 is bits 31:24.
REQ-016 SB: mem_we=4'b1000>>addr[1:0], mem_wdata={4{wdata[7:0]}}; SH: mem_we=1100 (addr[1]=0) or 0011, mem_wdata={2{wdata[15:0]}}; SW: 1111, wdata unchanged; loads: mem_we=0000.
REQ-017 mem_we/mem_wdata SHALL be 0 whenever mem_en=0.
REQ-018 WAIT SHALL hold until mem_rvalid=1 (no timeout); mem_rvalid=1 already in ACCESS cycle SHALL be accepted identically.
REQ-019 Edge where mem_rvalid seen: mem_rdata SHALL be aligned and captured; RESP next cycle.
REQ-020 Load align: select byte/half by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend; LW pass; req_mask 101-111 SHALL behave as LW.
REQ-021 Stores: resp_rdata=0.
REQ-022 RESP SHALL assert resp_valid for exactly one cycle, then IDLE; minimum aligned access = 4 cycles accept-to-ready.
REQ-023 mem_rvalid in IDLE or RESP SHALL be ignored.
REQ-024 req_valid while not ready SHALL be ignored (no queueing).

Reset
REQ-025 rst SHALL immediately force IDLE; req_ready=1, all other outputs 0.
REQ-026 Reset mid-operation SHALL abandon the access: no resp_valid, no further mem_en; a late mem_rvalid ignored.

Structure
REQ-027 Mask/MemWrite encodings and FSM state codes SHALL live in shared header MemAccess.vh, consistent with the decoder's encodings.
REQ-028 Load extraction/extension SHALL be a combinational sub-module load_align (inputs rdata, offset, mask; output 32-bit data).
REQ-029 Target 120-400 lines RTL total.

Verification
REQ-030 LB addr 0x00000003, mem_rdata 0x123456F0 -> resp_rdata 0xFFFFFFF0, misaligned 0.
REQ-031 SH addr 0x00000102, wdata 0x0000BEEF -> one-cycle mem_en, mem_addr 0x40, mem_we 0011, mem_wdata 0xBEEFBEEF.
REQ-032 LW addr 0x00000006 -> resp_valid at N+1 with misaligned=1, mem_en never asserted.
REQ-033 LHU addr 0x00000000, mem_rvalid delayed 5 cycles, rdata 0x8001FFFF -> resp_rdata 0x00008001; req_ready low throughout.
REQ-034 rst asserted during WAIT, then mem_rvalid=1 -> no resp_valid; req_ready=1 after reset.
REQ-035 Back-to-back SB addr 0x1 (wdata 0xAA) then LBU addr 0x1 -> mem_we 0100, mem_wdata 0xAAAAAAAA; second request accepted only after first resp_valid.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared encodings, FSM codes and alignment check for mem_access_unit
package mem_access_unit_pkg;

  // Load kinds carried on req_mask; codes 101-111 fall through to word behaviour
  localparam logic [2:0] MASK_LB  = 3'b000;
  localparam logic [2:0] MASK_LH  = 3'b001;
  localparam logic [2:0] MASK_LW  = 3'b010;
  localparam logic [2:0] MASK_LBU = 3'b011;
  localparam logic [2:0] MASK_LHU = 3'b100;

  localparam logic [1:0] MW_LOAD = 2'b00;
  localparam logic [1:0] MW_SB   = 2'b01;
  localparam logic [1:0] MW_SH   = 2'b10;
  localparam logic [1:0] MW_SW   = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  mask;
    logic [1:0]  memwrite;
  } req_t;

  function automatic logic is_misaligned(input logic [1:0] off, input logic [2:0] mask,
                                         input logic [1:0] memwrite);
    logic half;
    logic word;
    if (memwrite != MW_LOAD) begin
      half = (memwrite == MW_SH);
      word = (memwrite == MW_SW);
    end else begin
      half = (mask == MASK_LH) || (mask == MASK_LHU);
      word = !half && (mask != MASK_LB) && (mask != MASK_LBU);
    end
    return (half && off[0]) || (word && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// rtl/mem_access_unit_load_align.sv - big-endian byte/half extraction and extension of load data
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  mask,
  output logic [31:0] data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    // Offset 0 addresses the most significant byte lane
    case (offset)
      2'd0:    sel_byte = rdata[31:24];
      2'd1:    sel_byte = rdata[23:16];
      2'd2:    sel_byte = rdata[15:8];
      default: sel_byte = rdata[7:0];
    endcase
    sel_half = offset[1] ? rdata[15:0] : rdata[31:16];

    case (mask)
      MASK_LB:  data = {{24{sel_byte[7]}}, sel_byte};
      MASK_LH:  data = {{16{sel_half[15]}}, sel_half};
      MASK_LBU: data = {24'd0, sel_byte};
      MASK_LHU: data = {16'd0, sel_half};
      default:  data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-outstanding load/store unit with big-endian lanes and misalignment trap
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_mask,
  input  logic [1:0]  req_memwrite,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned
);

  logic [1:0]  state;
  req_t        req_q;
  logic [31:0] rdata_q;
  logic        misaligned_q;
  logic [31:0] load_data;
  logic        req_misaligned;

  assign req_misaligned = is_misaligned(req_addr[1:0], req_mask, req_memwrite);

  load_align u_load_align (
    .rdata  (mem_rdata),
    .offset (req_q.addr[1:0]),
    .mask   (req_q.mask),
    .data   (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      req_q        <= '0;
      rdata_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_q.addr     <= req_addr;
            req_q.wdata    <= req_wdata;
            req_q.mask     <= req_mask;
            req_q.memwrite <= req_memwrite;
            misaligned_q   <= req_misaligned;
            rdata_q        <= '0;
            state          <= req_misaligned ? ST_RESP : ST_ACCESS;
          end
        end
        ST_ACCESS, ST_WAIT: begin
          // Completion may already arrive in the access cycle itself
          if (mem_rvalid) begin
            rdata_q <= (req_q.memwrite == MW_LOAD) ? load_data : 32'd0;
            state   <= ST_RESP;
          end else begin
            state   <= ST_WAIT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_en    = (state == ST_ACCESS);
    mem_we    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == ST_ACCESS) begin
      mem_addr = req_q.addr[31:2];
      case (req_q.memwrite)
        MW_SB: begin
          mem_we    = 4'b1000 >> req_q.addr[1:0];
          mem_wdata = {4{req_q.wdata[7:0]}};
        end
        MW_SH: begin
          mem_we    = req_q.addr[1] ? 4'b0011 : 4'b1100;
          mem_wdata = {2{req_q.wdata[15:0]}};
        end
        MW_SW: begin
          mem_we    = 4'b1111;
          mem_wdata = req_q.wdata;
        end
        default: begin
          mem_we    = 4'b0000;
          mem_wdata = '0;
        end
      endcase
    end
  end

  assign req_ready       = (state == ST_IDLE);
  assign resp_valid      = (state == ST_RESP);
  assign resp_rdata      = resp_valid ? rdata_q : 32'd0;
  assign resp_misaligned = resp_valid & misaligned_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_mask;
  logic [1:0]  req_memwrite;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;

  int total = 0;
  int bad = 0;
  int en_cnt = 0;
  int resp_cnt = 0;
  int en_snap;
  int resp_snap;

  mem_access_unit dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_mask        (req_mask),
    .req_memwrite    (req_memwrite),
    .mem_en          (mem_en),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en === 1'b1) en_cnt++;
    if (resp_valid === 1'b1) resp_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] mask, input logic [1:0] mw);
    req_valid    = 1'b1;
    req_addr     = addr;
    req_wdata    = wdata;
    req_mask     = mask;
    req_memwrite = mw;
  endtask

  // Aligned access answered in the access cycle itself
  task automatic txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [2:0] mask, input logic [1:0] mw, input logic [31:0] rdata,
                     input logic [29:0] exp_addr, input logic [3:0] exp_we,
                     input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    @(negedge clk);
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    drive(addr, wdata, mask, mw);
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, ".en"}, 32'(mem_en), 32'd1);
    chk({tag, ".addr"}, 32'(mem_addr), 32'(exp_addr));
    chk({tag, ".we"}, 32'(mem_we), 32'(exp_we));
    chk({tag, ".wdata"}, mem_wdata, exp_wdata);
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    chk({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, ".rdata"}, resp_rdata, exp_rdata);
    chk({tag, ".mis"}, 32'(resp_misaligned), 32'd0);
    chk({tag, ".en_off"}, {31'd0, mem_en} | {28'd0, mem_we} | mem_wdata, 32'd0);
    @(negedge clk);
    chk({tag, ".resp_done"}, 32'(resp_valid), 32'd0);
  endtask

  task automatic mis(input string tag, input logic [31:0] addr, input logic [2:0] mask,
                     input logic [1:0] mw);
    en_snap = en_cnt;
    @(negedge clk);
    drive(addr, 32'h5555AAAA, mask, mw);
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, ".mis"}, 32'(resp_misaligned), 32'd1);
    chk({tag, ".rdata"}, resp_rdata, 32'd0);
    chk({tag, ".en"}, 32'(mem_en), 32'd0);
    @(negedge clk);
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    chk({tag, ".no_access"}, 32'(en_cnt - en_snap), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    req_mask = 3'd0;
    req_memwrite = 2'd0;
    mem_rvalid = 1'b0;
    mem_rdata = 32'd0;

    @(negedge clk);
    @(negedge clk);
    chk("rst.ready", 32'(req_ready), 32'd1);
    chk("rst.en", 32'(mem_en), 32'd0);
    chk("rst.we", 32'(mem_we), 32'd0);
    chk("rst.addr", 32'(mem_addr), 32'd0);
    chk("rst.wdata", mem_wdata, 32'd0);
    chk("rst.resp", {30'd0, resp_valid, resp_misaligned} | resp_rdata, 32'd0);
    rst = 1'b0;

    // Stray completion while idle
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEADBEEF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("idle_rvalid.resp", 32'(resp_valid), 32'd0);
    chk("idle_rvalid.ready", 32'(req_ready), 32'd1);

    txn("lb_neg", 32'h00000003, 32'd0, 3'b000, 2'b00, 32'h123456F0,
        30'h0, 4'b0000, 32'd0, 32'hFFFFFFF0);
    en_snap = en_cnt;
    txn("sh_hi", 32'h00000102, 32'h0000BEEF, 3'b000, 2'b10, 32'h11111111,
        30'h40, 4'b0011, 32'hBEEFBEEF, 32'd0);
    chk("sh_hi.en_once", 32'(en_cnt - en_snap), 32'd1);
    txn("lh_neg", 32'h00000002, 32'd0, 3'b001, 2'b00, 32'h0000F00D,
        30'h0, 4'b0000, 32'd0, 32'hFFFFF00D);
    txn("lb_pos", 32'h00000000, 32'd0, 3'b000, 2'b00, 32'h7F000000,
        30'h0, 4'b0000, 32'd0, 32'h0000007F);
    txn("mask7_lw", 32'h00000008, 32'd0, 3'b111, 2'b00, 32'hCAFEBABE,
        30'h2, 4'b0000, 32'd0, 32'hCAFEBABE);
    txn("sw", 32'h00000010, 32'h01020304, 3'b000, 2'b11, 32'hFFFFFFFF,
        30'h4, 4'b1111, 32'h01020304, 32'd0);

    mis("lw_mis", 32'h00000006, 3'b010, 2'b00);
    mis("sh_mis", 32'h00000103, 3'b000, 2'b10);

    // LHU with completion delayed by five cycles
    @(negedge clk);
    drive(32'h00000000, 32'd0, 3'b100, 2'b00);
    @(negedge clk);
    req_valid = 1'b0;
    chk("lhu.en", 32'(mem_en), 32'd1);
    chk("lhu.ready_access", 32'(req_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("lhu.wait%0d", i), {30'd0, req_ready, mem_en}, 32'd0);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h8001FFFF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("lhu.resp_valid", 32'(resp_valid), 32'd1);
    chk("lhu.rdata", resp_rdata, 32'h00008001);
    chk("lhu.ready_resp", 32'(req_ready), 32'd0);
    @(negedge clk);

    // Reset during WAIT abandons the access
    drive(32'h00000020, 32'd0, 3'b010, 2'b00);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstwait.in_wait", {30'd0, req_ready, mem_en}, 32'd0);
    en_snap = en_cnt;
    resp_snap = resp_cnt;
    rst = 1'b1;
    #1;
    chk("rstwait.ready_async", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h12345678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("rstwait.no_resp", 32'(resp_cnt - resp_snap), 32'd0);
    chk("rstwait.no_en", 32'(en_cnt - en_snap), 32'd0);
    chk("rstwait.ready", 32'(req_ready), 32'd1);

    // Back-to-back: SB then LBU held valid throughout
    drive(32'h00000001, 32'h000000AA, 3'b000, 2'b01);
    @(negedge clk);
    chk("b2b.sb_we", 32'(mem_we), 32'h4);
    chk("b2b.sb_wdata", mem_wdata, 32'hAAAAAAAA);
    chk("b2b.sb_addr", 32'(mem_addr), 32'd0);
    drive(32'h00000001, 32'd0, 3'b011, 2'b00);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h12AB5678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("b2b.sb_resp", 32'(resp_valid), 32'd1);
    chk("b2b.sb_rdata", resp_rdata, 32'd0);
    chk("b2b.ready_resp", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("b2b.idle_ready", 32'(req_ready), 32'd1);
    chk("b2b.idle_en", 32'(mem_en), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b.lbu_en", 32'(mem_en), 32'd1);
    chk("b2b.lbu_we", 32'(mem_we), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h12AB5678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("b2b.lbu_resp", 32'(resp_valid), 32'd1);
    chk("b2b.lbu_rdata", resp_rdata, 32'h000000AB);
    @(negedge clk);
    chk("b2b.end_ready", 32'(req_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
